// File: rtl/servo_pkg.sv
// Definitions shared by the servo PWM decoder and generator.
// Covers duty width, default timing, legal pulse range and FSM state encoding.
package servo_pkg;

    localparam int DUTY_W              = 10;
    localparam int SERVO_CLKS_PER_UNIT = 488;
    localparam int SERVO_MIN_UNITS     = 26;
    localparam int SERVO_MAX_UNITS     = 128;
    localparam int SERVO_NEUTRAL_UNITS = 77;

    localparam logic [DUTY_W-1:0] DUTY_SAT = '1;

    typedef enum logic [1:0] {
        ST_WAIT_LOW     = 2'd0,
        ST_WAIT_RISE    = 2'd1,
        ST_MEASURE_HIGH = 2'd2
    } servo_state_e;

endpackage

// File: rtl/servo_input_sync.sv
// Brings the asynchronous servo input into the clock domain.
// Provides the synchronized level plus single-cycle rise and fall flags.
module servo_input_sync (
    input  logic i_clk,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Left out of reset so the level seen right after reset is the true input level.
    always_ff @(posedge i_clk) begin
        r_meta <= i_async;
        r_sync <= r_meta;
        r_hist <= r_sync;
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time in duty units, rounded to the nearest unit.
// Flags out-of-range pulses and loss of the pulse train.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CLKS_PER_UNIT = SERVO_CLKS_PER_UNIT,
    parameter int MIN_UNITS     = SERVO_MIN_UNITS,
    parameter int MAX_UNITS     = SERVO_MAX_UNITS,
    parameter int TIMEOUT_UNITS = 1280
) (
    input  logic              clk25mhz,
    input  logic              reset,
    input  logic              servoSignal,
    output logic [DUTY_W-1:0] duty_cycle_output,
    output logic              duty_valid,
    output logic              range_error,
    output logic              signal_lost,
    output logic [15:0]       testing
);

    localparam int SUB_W  = $clog2(CLKS_PER_UNIT);
    localparam int IDLE_W = $clog2(TIMEOUT_UNITS + 1);

    localparam logic [SUB_W-1:0]  SUB_LAST     = SUB_W'(CLKS_PER_UNIT - 1);
    localparam logic [SUB_W-1:0]  SUB_HALF     = SUB_W'(CLKS_PER_UNIT / 2);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT   = IDLE_W'(TIMEOUT_UNITS);
    localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(TIMEOUT_UNITS - 1);
    localparam logic [DUTY_W-1:0] DUTY_MIN     = DUTY_W'(MIN_UNITS);
    localparam logic [DUTY_W-1:0] DUTY_MAX     = DUTY_W'(MAX_UNITS);
    localparam logic [DUTY_W-1:0] DUTY_NEUTRAL = DUTY_W'(SERVO_NEUTRAL_UNITS);

    function automatic logic [DUTY_W-1:0] round_sat(input logic [DUTY_W-1:0] width,
                                                    input logic              round_up);
        logic [DUTY_W:0] sum;
        sum = {1'b0, width} + {{DUTY_W{1'b0}}, round_up};
        return sum[DUTY_W] ? DUTY_SAT : sum[DUTY_W-1:0];
    endfunction

    logic w_level;
    logic w_rise;
    logic w_fall;

    servo_input_sync u_sync (
        .i_clk   (clk25mhz),
        .i_async (servoSignal),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    servo_state_e       r_state;
    servo_state_e       w_state_nxt;
    logic               w_start;
    logic               w_done;
    logic [SUB_W-1:0]   r_sub;
    logic [DUTY_W-1:0]  r_width;
    logic [SUB_W-1:0]   r_idle_sub;
    logic [IDLE_W-1:0]  r_idle;
    logic [DUTY_W-1:0]  r_duty;
    logic               r_valid;
    logic               r_err;
    logic               r_lost;
    logic               w_edge;
    logic               w_timeout_hit;
    logic [DUTY_W-1:0]  w_result;
    logic               w_in_range;

    assign w_edge        = w_rise | w_fall;
    // Fires once, on the unit wrap that brings the idle count up to the limit.
    assign w_timeout_hit = !w_edge && (r_idle_sub == SUB_LAST) && (r_idle == IDLE_LAST);
    assign w_result      = round_sat(r_width, r_sub >= SUB_HALF);
    assign w_in_range    = (w_result >= DUTY_MIN) && (w_result <= DUTY_MAX);

    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            r_state <= ST_WAIT_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        if (w_timeout_hit) begin
            w_state_nxt = ST_WAIT_LOW;
        end else begin
            case (r_state)
                ST_WAIT_LOW: begin
                    if (!w_level) w_state_nxt = ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_MEASURE_HIGH;
                        w_start     = 1'b1;
                    end
                end
                ST_MEASURE_HIGH: begin
                    if (w_fall) begin
                        w_state_nxt = ST_WAIT_RISE;
                        w_done      = 1'b1;
                    end
                end
                default: w_state_nxt = ST_WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            r_sub      <= '0;
            r_width    <= '0;
            r_idle_sub <= '0;
            r_idle     <= '0;
            r_duty     <= DUTY_NEUTRAL;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if (w_start) begin
                r_sub   <= '0;
                r_width <= '0;
            end else if (r_state == ST_MEASURE_HIGH) begin
                if (r_sub == SUB_LAST) begin
                    r_sub <= '0;
                    if (r_width != DUTY_SAT) r_width <= r_width + 1'b1;
                end else begin
                    r_sub <= r_sub + 1'b1;
                end
            end

            if (w_done) begin
                if (w_in_range) begin
                    r_duty  <= w_result;
                    r_valid <= 1'b1;
                    r_lost  <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end

            if (w_timeout_hit) r_lost <= 1'b1;

            if (w_edge) begin
                r_idle_sub <= '0;
                r_idle     <= '0;
            end else if (r_idle != IDLE_LIMIT) begin
                if (r_idle_sub == SUB_LAST) begin
                    r_idle_sub <= '0;
                    r_idle     <= r_idle + 1'b1;
                end else begin
                    r_idle_sub <= r_idle_sub + 1'b1;
                end
            end
        end
    end

    assign duty_cycle_output = r_duty;
    assign duty_valid        = r_valid;
    assign range_error       = r_err;
    assign signal_lost       = r_lost;
    assign testing           = {r_state, r_lost, 3'b000, r_duty};

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with the duty unit scaled to 8 clocks,
// so 20 ms frames and the 1280-unit timeout fit in a short run.
module tb_servo_pwm_decoder;

    localparam int CPU = 8;

    logic        clk25mhz    = 1'b0;
    logic        reset       = 1'b1;
    logic        servoSignal = 1'b0;
    logic [9:0]  duty_cycle_output;
    logic        duty_valid;
    logic        range_error;
    logic        signal_lost;
    logic [15:0] testing;

    int checks = 0;
    int errors = 0;
    int both_total = 0;
    int nv, ne, nb, idx, c;

    always #20 clk25mhz = ~clk25mhz;

    servo_pwm_decoder #(
        .CLKS_PER_UNIT (CPU),
        .MIN_UNITS     (26),
        .MAX_UNITS     (128),
        .TIMEOUT_UNITS (1280)
    ) dut (
        .clk25mhz          (clk25mhz),
        .reset             (reset),
        .servoSignal       (servoSignal),
        .duty_cycle_output (duty_cycle_output),
        .duty_valid        (duty_valid),
        .range_error       (range_error),
        .signal_lost       (signal_lost),
        .testing           (testing)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25mhz);
        #1;
    endtask

    // h cycles high then l cycles low; idx_o is the loop step of the first strobe.
    task automatic pulse_watch(input int h, input int l,
                               output int nv_o, output int ne_o, output int nb_o, output int idx_o);
        nv_o = 0; ne_o = 0; nb_o = 0; idx_o = -1;
        for (int i = 0; i < h + l; i++) begin
            servoSignal = (i < h);
            tick();
            if ((duty_valid || range_error) && idx_o < 0) idx_o = i;
            if (duty_valid) nv_o++;
            if (range_error) ne_o++;
            if (duty_valid && range_error) nb_o++;
        end
        both_total += nb_o;
    endtask

    initial begin
        repeat (5) tick();
        check("reset_duty", duty_cycle_output, 77);
        check("reset_valid", duty_valid, 0);
        check("reset_err", range_error, 0);
        check("reset_lost", signal_lost, 0);
        check("reset_testing", testing, 16'h004D);
        reset = 1'b0;
        repeat (5) tick();
        check("idle_low_state", testing[15:14], 2'd1);

        // 51-unit pulse in a 1024-unit frame, two frames
        for (int p = 0; p < 2; p++) begin
            pulse_watch(409, 1024 * CPU - 409, nv, ne, nb, idx);
            check("frame_valid_count", nv, 1);
            check("frame_err_count", ne, 0);
            check("frame_duty", duty_cycle_output, 51);
        end

        pulse_watch(614, 100, nv, ne, nb, idx);
        check("d77_valid", nv, 1);
        check("d77_duty", duty_cycle_output, 77);

        pulse_watch(739, 100, nv, ne, nb, idx);
        check("d92_valid", nv, 1);
        check("d92_latency", idx, 741);
        check("d92_duty", duty_cycle_output, 92);

        pulse_watch(1225, 100, nv, ne, nb, idx);
        check("over_err", ne, 1);
        check("over_valid", nv, 0);
        check("over_duty_hold", duty_cycle_output, 92);

        pulse_watch(1028, 100, nv, ne, nb, idx);
        check("max_valid", nv, 1);
        check("max_duty", duty_cycle_output, 128);
        pulse_watch(1029, 100, nv, ne, nb, idx);
        check("above_max_err", ne, 1);
        check("above_max_duty", duty_cycle_output, 128);

        pulse_watch(205, 100, nv, ne, nb, idx);
        check("min_valid", nv, 1);
        check("min_duty", duty_cycle_output, 26);
        pulse_watch(204, 100, nv, ne, nb, idx);
        check("below_min_err", ne, 1);
        check("below_min_duty", duty_cycle_output, 26);

        // loss of signal while held low
        pulse_watch(409, 100, nv, ne, nb, idx);
        check("pre_loss_duty", duty_cycle_output, 51);
        c = 0;
        while (!signal_lost && c < 12000) begin
            servoSignal = 1'b0;
            tick();
            c++;
        end
        check("loss_cycles", c, 10143);
        check("loss_flag", signal_lost, 1);
        check("loss_state", testing[15:13], 3'b001);
        repeat (300) tick();
        check("loss_held", testing[15:13], 3'b011);
        pulse_watch(614, 100, nv, ne, nb, idx);
        check("recover_valid", nv, 1);
        check("recover_duty", duty_cycle_output, 77);
        check("recover_lost", signal_lost, 0);

        // reset landing on the fall-processing edge
        pulse_watch(409, 100, nv, ne, nb, idx);
        check("pre_rf_duty", duty_cycle_output, 51);
        servoSignal = 1'b1;
        repeat (409) tick();
        servoSignal = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rf_valid", duty_valid, 0);
        check("rf_err", range_error, 0);
        check("rf_duty", duty_cycle_output, 77);
        reset = 1'b0;
        repeat (20) tick();

        // reset partway through a high pulse, input still high at release
        pulse_watch(739, 100, nv, ne, nb, idx);
        check("pre_mid_duty", duty_cycle_output, 92);
        servoSignal = 1'b1;
        repeat (100) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("mid_rst_testing", testing, 16'h004D);
        check("mid_rst_valid", duty_valid, 0);
        check("mid_rst_err", range_error, 0);
        reset = 1'b0;
        pulse_watch(300, 0, nv, ne, nb, idx);
        check("mid_high_state", testing[15:14], 2'd0);
        pulse_watch(0, 100, nv, ne, nb, idx);
        check("mid_discard_strobes", nv + ne, 0);
        pulse_watch(739, 100, nv, ne, nb, idx);
        check("mid_next_valid", nv, 1);
        check("mid_next_duty", duty_cycle_output, 92);

        check("never_both", both_total, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_UNIT, default 488, clk25mhz cycles per duty unit (20 ms / 1024).
REQ-002 SHALL have parameter MIN_UNITS, default 26, smallest legal pulse in units (~0.5 ms).
REQ-003 SHALL have parameter MAX_UNITS, default 128, largest legal pulse in units (~2.5 ms).
REQ-004 SHALL have parameter TIMEOUT_UNITS, default 1280, edge-free units before loss is declared (~25 ms).
REQ-005 SHALL have port clk25mhz  input  1  sole clock, 25 MHz.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port servoSignal  input  1  asynchronous servo PWM pulse train.
REQ-008 SHALL have port duty_cycle_output  output  10  last legal pulse width, in units.
REQ-009 SHALL have port duty_valid  output  1  one-cycle strobe when duty_cycle_output updates.
REQ-010 SHALL have port range_error  output  1  one-cycle strobe on a measured pulse outside [MIN_UNITS, MAX_UNITS].
REQ-011 SHALL have port signal_lost  output  1  level; no edge for TIMEOUT_UNITS units.
REQ-012 SHALL have port testing  output  16  debug: {state[1:0], signal_lost, 3'b000, duty_cycle_output}.

Function
REQ-013 SHALL pass servoSignal through a 2-flop synchronizer plus a history flop; rise = history 0 and sync 1, fall = history 1 and sync 0.
REQ-014 SHALL implement FSM WAIT_LOW -> WAIT_RISE -> MEASURE_HIGH -> WAIT_RISE; WAIT_LOW exits when synced input is 0, so a pulse already high at reset is discarded.
REQ-015 SHALL, on a rise in WAIT_RISE, clear the sub-unit counter (0..CLKS_PER_UNIT-1) and the width counter, then enter MEASURE_HIGH.
REQ-016 SHALL, in MEASURE_HIGH, increment the width counter on each sub-unit wrap; the width counter saturates at 1023.
REQ-017 SHALL, on a fall, compute the result as width plus 1 if sub-unit count >= CLKS_PER_UNIT/2, saturating at 1023.
REQ-018 SHALL, if the result is within [MIN_UNITS, MAX_UNITS], load duty_cycle_output, pulse duty_valid and clear signal_lost; otherwise it SHALL pulse range_error and hold duty_cycle_output.
REQ-019 SHALL register outputs so that duty_valid or range_error is high during the cycle after the third clk25mhz edge that samples servoSignal low.
REQ-020 SHALL never assert duty_valid and range_error in the same cycle.
REQ-021 SHALL keep an edge-free unit counter, cleared on any rise or fall and saturating at TIMEOUT_UNITS.
REQ-022 SHALL, when the edge-free counter reaches TIMEOUT_UNITS, set signal_lost and enter WAIT_LOW; this covers input stuck high or stuck low.
REQ-023 SHALL hold signal_lost until the next duty_valid or reset.
REQ-024 SHALL, if reset coincides with a fall, let reset win and emit no strobe.

Reset
REQ-025 SHALL, on reset, set state WAIT_LOW, all counters 0, duty_cycle_output 77 (neutral), and duty_valid, range_error and signal_lost 0.
REQ-026 SHALL, on reset mid-pulse, discard that pulse; the first measurement starts at the next rise after input is seen low.

Structure
REQ-027 SHALL take duty width (10), default CLKS_PER_UNIT, MIN/MAX/neutral values and the FSM state encoding from a shared package servo_pkg, which the servo PWM generator also uses.
REQ-028 SHALL instantiate sub-module servo_input_sync (synchronizer plus edge detect, outputs level, rise and fall).

Verification
REQ-029 Bench SHALL check: 25000-cycle high pulse, 20 ms period -> duty_valid once per period, duty_cycle_output 51.
REQ-030 Bench SHALL check: 37500-cycle pulse -> duty 77; 45000-cycle pulse -> duty 92, strobe 3 cycles after first sampled-low edge.
REQ-031 Bench SHALL check: 75000-cycle pulse after a 92 reading -> range_error one cycle, duty_cycle_output stays 92, no duty_valid.
REQ-032 Bench SHALL check: input held low 700000 cycles -> signal_lost 1 at edge-free count 1280; next 37500-cycle pulse -> duty 77, signal_lost 0.
REQ-033 Bench SHALL check: reset asserted 10000 cycles into a high pulse -> no strobe for that pulse; outputs 77/0/0/0; next full pulse measured correctly.
REQ-034 Bench SHALL check: input high at reset release -> first high period ignored; state WAIT_LOW until input is low.
